win_checker: RTL

- Downstream of the board datapath; consumes each accepted stone placement (row, col, player).
- Walks the board through a registered read port to decide whether that stone completes WIN_LEN in a row.
- Checks horizontal, vertical, diagonal and anti-diagonal lines.
- Its sticky win/winner outputs drive the win LEDs (LEDR[7] player0, LEDG[0] player1) and gate further play.

---
 rtl/gobang_pkg.sv | 39 +++
 rtl/coord_stepper.sv | 54 +++++
 rtl/win_checker.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gobang_pkg.sv
// Shared gobang types: cell codes, walk directions and checker states.
// Imported by the board datapath and the win checker.
package gobang_pkg;

  localparam int DEF_N       = 16;
  localparam int DEF_WIN_LEN = 5;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b01;
  localparam logic [1:0] CELL_P1    = 2'b10;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_e;

  typedef enum logic {
    PH_POS,
    PH_NEG
  } phase_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIR_INIT,
    S_REQ,
    S_CHK,
    S_DIR_END,
    S_DONE
  } wc_state_e;

  function automatic logic [1:0] own_code(
    input logic p
  );
    return p ? CELL_P1 : CELL_P0;
  endfunction

endpackage

// File: rtl/coord_stepper.sv
// One step along a board direction from a cursor, with bounds check.
// Arithmetic is CW+1 bits signed so stepping off an edge never wraps.
module coord_stepper
  import gobang_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = 4
) (
  input  logic [CW-1:0] cur_row,
  input  logic [CW-1:0] cur_col,
  input  dir_e          dir,
  input  phase_e        phase,
  output logic [CW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output logic          in_bounds
);

  localparam logic signed [CW:0] P1 =
    {{CW{1'b0}}, 1'b1};
  localparam logic signed [CW:0] Z0 = '0;
  localparam logic signed [CW:0] M1 = '1;

  logic signed [CW:0] dr;
  logic signed [CW:0] dc;
  logic signed [CW:0] r_s;
  logic signed [CW:0] c_s;

  always_comb begin
    dr = Z0;
    dc = Z0;
    unique case (dir)
      DIR_H: begin dr = Z0; dc = P1; end
      DIR_V: begin dr = P1; dc = Z0; end
      DIR_D: begin dr = P1; dc = P1; end
      DIR_A: begin dr = P1; dc = M1; end
      default: begin dr = Z0; dc = Z0; end
    endcase
    if (phase == PH_NEG) begin
      dr = -dr;
      dc = -dc;
    end
  end

  assign r_s = $signed({1'b0, cur_row}) + dr;
  assign c_s = $signed({1'b0, cur_col}) + dc;

  // stepping past 2^CW-1 lands negative in CW+1 bits, also rejected
  assign in_bounds = (r_s >= Z0) && (int'(r_s) < N)
                  && (c_s >= Z0) && (int'(c_s) < N);

  assign nxt_row = r_s[CW-1:0];
  assign nxt_col = c_s[CW-1:0];

endmodule

// File: rtl/win_checker.sv
// Walks the board from a freshly placed stone in four directions and
// raises a sticky win when WIN_LEN or more stones line up.
module win_checker
  import gobang_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int CW      = 4,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic          player,
  output logic [CW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [1:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          win,
  output logic          winner
);

  localparam int CNTW = $clog2(WIN_LEN + 1);
  localparam logic [CNTW-1:0] CNT_MAX =
    CNTW'(WIN_LEN);
  localparam logic [CNTW-1:0] CNT_ONE =
    CNTW'(1);

  wc_state_e state_q, state_d;
  dir_e      dir_q, dir_d;
  phase_e    phase_q, phase_d;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   org_row_q, org_row_d;
  logic [CW-1:0]   org_col_q, org_col_d;
  logic [CW-1:0]   cur_row_q, cur_row_d;
  logic [CW-1:0]   cur_col_q, cur_col_d;
  logic [CW-1:0]   rd_row_q, rd_row_d;
  logic [CW-1:0]   rd_col_q, rd_col_d;
  logic            ply_q, ply_d;
  logic            win_q, win_d;
  logic            winner_q, winner_d;

  logic [CW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;
  logic          nxt_in;

  coord_stepper #(
    .N  (N),
    .CW (CW)
  ) u_step (
    .cur_row   (cur_row_q),
    .cur_col   (cur_col_q),
    .dir       (dir_q),
    .phase     (phase_q),
    .nxt_row   (nxt_row),
    .nxt_col   (nxt_col),
    .in_bounds (nxt_in)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_H;
      phase_q   <= PH_POS;
      cnt_q     <= '0;
      org_row_q <= '0;
      org_col_q <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      ply_q     <= 1'b0;
      win_q     <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      org_row_q <= org_row_d;
      org_col_q <= org_col_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      rd_row_q  <= rd_row_d;
      rd_col_q  <= rd_col_d;
      ply_q     <= ply_d;
      win_q     <= win_d;
      winner_q  <= winner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    org_row_d = org_row_q;
    org_col_d = org_col_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    ply_d     = ply_q;
    win_d     = win_q;
    winner_d  = winner_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !win_q) begin
          org_row_d = row;
          org_col_d = col;
          ply_d     = player;
          dir_d     = DIR_H;
          state_d   = S_DIR_INIT;
        end
      end
      S_DIR_INIT: begin
        cnt_d     = CNT_ONE;
        cur_row_d = org_row_q;
        cur_col_d = org_col_q;
        phase_d   = PH_POS;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (!nxt_in || cnt_q == CNT_MAX) begin
          if (phase_q == PH_POS) begin
            phase_d   = PH_NEG;
            cur_row_d = org_row_q;
            cur_col_d = org_col_q;
          end else begin
            state_d = S_DIR_END;
          end
        end else begin
          // address goes out this cycle; data returns in CHK
          rd_row_d = nxt_row;
          rd_col_d = nxt_col;
          state_d  = S_CHK;
        end
      end
      S_CHK: begin
        if (rd_data == own_code(ply_q)) begin
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_ONE;
          cur_row_d = nxt_row;
          cur_col_d = nxt_col;
          state_d   = S_REQ;
        end else if (phase_q == PH_POS) begin
          phase_d   = PH_NEG;
          cur_row_d = org_row_q;
          cur_col_d = org_col_q;
          state_d   = S_REQ;
        end else begin
          state_d = S_DIR_END;
        end
      end
      S_DIR_END: begin
        if (cnt_q >= CNT_MAX) begin
          win_d    = 1'b1;
          winner_d = ply_q;
          state_d  = S_DONE;
        end else if (dir_q == DIR_A) begin
          state_d = S_DONE;
        end else begin
          dir_d   = dir_e'(dir_q + 2'd1);
          state_d = S_DIR_INIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_row = rd_row_d;
  assign rd_col = rd_col_d;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign win    = win_q;
  assign winner = winner_q;

endmodule
